// File: rtl/fetch_stage_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_stage_pkg
//  Description : Opcode values, the NOP word and fetch FSM state encodings
//                shared between fetch, decode and control.
//  Revision    : 1.0  initial release
// ============================================================================
package fetch_stage_pkg;

    localparam int         c_data_w    = 16;
    localparam int         c_op_w      = 5;
    localparam int         c_state_w   = 2;

    localparam logic [c_op_w-1:0]   c_op_halt   = 5'b00000;
    localparam logic [c_op_w-1:0]   c_op_nop    = 5'b00001;
    localparam logic [c_data_w-1:0] c_nop_instr = {c_op_nop, 11'b0};

    localparam logic [c_state_w-1:0] c_st_fetch = 2'd0;
    localparam logic [c_state_w-1:0] c_st_wait  = 2'd1;
    localparam logic [c_state_w-1:0] c_st_hold  = 2'd2;
    localparam logic [c_state_w-1:0] c_st_halt  = 2'd3;

endpackage
`default_nettype wire

// File: rtl/fetch_pc_reg.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_pc_reg
//  Description : Program counter with load enable; next value is either the
//                sequential PC+2 or an externally supplied redirect target.
//  Revision    : 1.0  initial release
// ============================================================================
module fetch_pc_reg
    import fetch_stage_pkg::*;
#(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_load,
    input  logic        i_sel_redirect,
    input  logic [15:0] i_redirect_pc,
    output logic [15:0] o_pc,
    output logic [15:0] o_pc_inc
);

    logic [15:0] r_pc;
    logic [15:0] w_pc_inc;
    logic [15:0] w_pc_next;

    // Plain 16-bit add: FFFE wraps to 0000 by design.
    assign w_pc_inc  = r_pc + 16'd2;
    assign w_pc_next = i_sel_redirect ? i_redirect_pc : w_pc_inc;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pc <= RESET_PC;
        end else if (i_load) begin
            r_pc <= w_pc_next;
        end
    end

    assign o_pc     = r_pc;
    assign o_pc_inc = w_pc_inc;

endmodule
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_stage
//  Description : Instruction fetch: one outstanding imem read at a time,
//                decode stall, branch redirect with squash, stop on HALT.
//  Revision    : 1.0  initial release
// ============================================================================
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [15:0] RESET_PC  = 16'h0000,
    parameter logic [15:0] NOP_INSTR = c_nop_instr
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_rdy,
    input  logic [15:0] imem_data,
    input  logic        stall,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    output logic [15:0] instruction,
    output logic [15:0] pc_plus2,
    output logic        if_valid,
    output logic        halted
);

    logic [c_state_w-1:0] r_state;
    logic [c_state_w-1:0] w_next_state;
    logic                 r_run;
    logic                 r_squash;
    logic [15:0]          r_instr;
    logic [15:0]          r_pc_plus2;

    logic [15:0]          w_pc;
    logic [15:0]          w_pc_inc;
    logic                 w_redirect_act;
    logic                 w_capture;
    logic                 w_accept;
    logic                 w_halt_op;
    logic                 w_pending;
    logic                 w_pc_load;

    fetch_pc_reg #(
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk            (clk),
        .rst            (rst),
        .i_load         (w_pc_load),
        .i_sel_redirect (w_redirect_act),
        .i_redirect_pc  (redirect_pc),
        .o_pc           (w_pc),
        .o_pc_inc       (w_pc_inc)
    );

    assign w_redirect_act = redirect && (r_state != c_st_halt);
    assign w_capture      = imem_req && imem_rdy && !redirect;
    assign w_accept       = (r_state == c_st_hold) && !stall && !redirect;
    assign w_halt_op      = (r_instr[15:11] == c_op_halt);
    assign w_pc_load      = w_redirect_act || (w_accept && !w_halt_op);
    // A request is in flight at memory either because we are driving it or
    // because an earlier one was abandoned by a redirect and not yet answered.
    assign w_pending      = imem_req || r_squash;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= c_st_fetch;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_st_fetch: begin
                if (imem_req) begin
                    w_next_state = imem_rdy ? c_st_hold : c_st_wait;
                end
            end
            c_st_wait: begin
                if (imem_rdy) begin
                    w_next_state = c_st_hold;
                end
            end
            c_st_hold: begin
                if (!stall) begin
                    w_next_state = w_halt_op ? c_st_halt : c_st_fetch;
                end
            end
            c_st_halt: begin
                w_next_state = c_st_halt;
            end
            default: begin
                w_next_state = c_st_fetch;
            end
        endcase
        if (w_redirect_act) begin
            w_next_state = c_st_fetch;
        end
    end

    // ------------------------------------------------------------------
    // Output logic
    // ------------------------------------------------------------------
    always_comb begin
        imem_req    = 1'b0;
        if_valid    = 1'b0;
        halted      = 1'b0;
        instruction = NOP_INSTR;
        case (r_state)
            c_st_fetch: begin
                // Held off until the first edge after reset and while the
                // abandoned request is still being drained.
                imem_req = r_run && !r_squash;
            end
            c_st_wait: begin
                imem_req = 1'b1;
            end
            c_st_hold: begin
                if_valid    = 1'b1;
                instruction = r_instr;
            end
            c_st_halt: begin
                halted = 1'b1;
            end
            default: begin
                imem_req = 1'b0;
            end
        endcase
    end

    assign imem_addr = w_pc;
    assign pc_plus2  = r_pc_plus2;

    // ------------------------------------------------------------------
    // Datapath and control flags
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_run      <= 1'b0;
            r_squash   <= 1'b0;
            r_instr    <= NOP_INSTR;
            r_pc_plus2 <= RESET_PC + 16'd2;
        end else begin
            r_run <= 1'b1;
            if (w_redirect_act) begin
                // A response landing in the redirect cycle itself retires the
                // old request, so nothing is left to drop.
                r_squash <= w_pending && !imem_rdy;
            end else if (r_squash && imem_rdy) begin
                r_squash <= 1'b0;
            end
            if (w_capture) begin
                r_instr    <= imem_data;
                r_pc_plus2 <= w_pc_inc;
            end
        end
    end

endmodule
`default_nettype wire
